// File: rtl/rr_encoder4_pkg.sv
// Shared types and constants for the 4-way round-robin encoder.
package rr_enc_pkg;

  localparam int unsigned N_REQ = 4;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // True when two or more request bits are set.
  function automatic logic multi_req(input logic [N_REQ-1:0] r);
    return (r & (r - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/rr_encoder4_pick4.sv
// Combinational rotating-priority picker: first set request bit at or above ptr, wrapping.
module rr_pick4
  import rr_enc_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Scan offsets 0..3 from ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr + i[1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_encoder4.sv
// Sequential 4-to-1 round-robin encoder with ack handshake.
// Optional registered collide output enabled by `RR_ENC_COLLISION_EN.
module rr_encoder4
  import rr_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       ack,
  output logic       en,
  output logic [1:0] sel
`ifdef RR_ENC_COLLISION_EN
  ,
  output logic       collide
`endif
);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt, sel_nxt;
  logic [1:0] pick_base, pick_idx;
  logic       found;
  logic [N_REQ-1:0] req;

  assign req = {D, C, B, A};

  // While granted, the next pick starts just past the current grant, which is
  // exactly the pointer value that will be stored on ack; this lets one picker
  // serve both the IDLE pick and the back-to-back re-pick.
  assign pick_base = (state == GRANT) ? sel + 2'd1 : ptr;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_base),
    .found (found),
    .idx   (pick_idx)
  );

  // State register doubles as the registered grant-valid output.
  assign en = (state == GRANT);

  // Next-state: grant from IDLE, hold until ack, rotate and re-pick on ack.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_nxt = sel + 2'd1;
          if (found) begin
            sel_nxt = pick_idx;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant index and rotation pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= IDX_A;
      ptr   <= IDX_A;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

`ifdef RR_ENC_COLLISION_EN
  logic grant_new;

  assign grant_new = found && ((state == IDLE) || ack);

  // Flag contested decisions for exactly the first cycle of the new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide <= 1'b0;
    end else begin
      collide <= grant_new && multi_req(req);
    end
  end
`endif

endmodule
